traffic_phase_controller: RTL
=============================

# traffic_phase_controller

Cycle-level sequencer for the two-road intersection. It replaces the counter/latch/decode chain with one registered state machine. It owns the phase timer and the police override latch, and it extends green on sustained crowd. It drives per-road light codes and per-road remaining-seconds values in binary; these feed the existing BCD converter and the display logic downstream.

## Interface
Parameters:
- A_GO_TIME, 90, road A green duration in ticks
- B_GO_TIME, 30, road B green duration in ticks
- CLEAR_TIME, 5, amber duration in ticks
- CROWD_TICKS, 10, consecutive crowded ticks before green is held

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle strobe, one per second; the timer advances only on tick
- crowd_a  in  1  road A congestion level
- crowd_b  in  1  road B congestion level
- police_a  in  1  police request for A green; pulse of at least 1 cycle
- police_b  in  1  police request for B green; pulse of at least 1 cycle
- police_clr  in  1  pulse that releases the police override
- light_a  out  2  road A light code
- light_b  out  2  road B light code
- time_a  out  7  ticks until road A's light changes; 7'h7F means blank
- time_b  out  7  ticks until road B's light changes; 7'h7F means blank
- hold_active  out  1  green is currently frozen by crowd hold

## Operation
- States:
  - A_GO: A green, B red.
  - A_CLEAR: A amber, B red.
  - B_GO: B green, A red.
  - B_CLEAR: B amber, A red.
  - POL_A: A green, B red.
  - POL_B: B green, A red.
- Normal cycle is A_GO → A_CLEAR → B_GO → B_CLEAR → A_GO.
- Phase timer is 7 bits:
  - On entry to a state, the timer loads that state's duration.
  - On each tick, the timer decrements.
  - A tick that arrives with timer==1 causes the transition on that edge and loads the next state's duration. Each phase therefore lasts exactly its duration in ticks.
- Remaining-time outputs:
  - time_a: equals timer in A_GO, A_CLEAR and B_CLEAR; equals timer+CLEAR_TIME in B_GO.
  - time_b: equals timer in B_GO, B_CLEAR and A_CLEAR; equals timer+CLEAR_TIME in A_GO.
- Police override:
  - police_a high in any cycle enters POL_A on the next edge, from any state. police_b does the same for POL_B.
  - If police_a and police_b are high together, police_a wins.
  - A police request while already in POL_x switches directly to the other police state.
  - In POL_x both times read 7'h7F and the timer is frozen.
  - police_clr in POL_A goes to A_CLEAR with the timer loaded to CLEAR_TIME; in POL_B it goes to B_CLEAR.
  - A police request beats police_clr in the same cycle.
  - police_clr is ignored outside the police states.
- Crowd hold:
  - Only active in A_GO (using crowd_a) or B_GO (using crowd_b).
  - A saturating counter counts consecutive ticks on which the active road's crowd input is high, up to CROWD_TICKS.
  - When the counter is saturated and crowd is still high, ticks do not decrement the timer and hold_active=1.
  - When crowd goes low, the counter clears, hold_active drops on the next edge, and decrement resumes on the next tick.
  - The counter clears on every state change.
  - There is no hold in CLEAR or police states.
- Width rules:
  - A_GO_TIME+CLEAR_TIME ≤ 126 and B_GO_TIME+CLEAR_TIME ≤ 126, so 7'h7F is never a valid count.
  - All durations are ≥ 1.
  - Additions are 7-bit and cannot overflow under these rules.

## Timing
- Reset values:
  - state A_GO, timer 90
  - light_a GREEN, light_b RED
  - time_a 90, time_b 95
  - hold_active 0
  - crowd counter 0
- All outputs are registered, so outputs reflect a state change one clk after the causing edge.
- The police reaction has 1-cycle latency and does not wait for tick.
- Reset asserted mid-phase or during police override forces the reset values immediately. The police latch is cleared.
- If tick and a police request arrive in the same cycle, the police request wins and the tick is discarded.

## Configuration
- TRAFFIC_CROWD_HOLD_EN defined: crowd counter and hold logic are built as described.
- Not defined:
  - crowd_a and crowd_b are ignored and hold_active is tied to 0.
  - The timer always decrements on tick.
  - The ports remain present.

## Structure
- Package traffic_pkg holds the following shared definitions:
  - state enum (six states)
  - light codes: RED 2'b00, AMBER 2'b01, GREEN 2'b10
  - blank constant 7'h7F
  - default duration constants
- Sub-module crowd_monitor contains the saturating consecutive-tick counter. Its I/O is clk, reset_n, tick, crowd, clear, and saturated.

## Test plan
- Reset release, 90 ticks → on the 90th tick, A_CLEAR is entered with light_a AMBER and time_a=time_b=5. After 5 more ticks, B_GO is entered with time_b=30 and time_a=35.
- Full cycle of 130 ticks → returns to A_GO with time_a=90. No illegal light combination occurs at any point.
- police_b pulse at A_GO timer=40 → next cycle POL_B with light_b GREEN, light_a RED and both times 7'h7F. Extra ticks cause no change. Then police_clr → B_CLEAR with time=5.
- police_a and police_b high in the same cycle → POL_A.
- crowd_a high for 15 ticks starting at A_GO timer=50 → timer reaches 40 and holds with hold_active=1. Crowd drops → decrement resumes on the next tick (40→39).
- Build without TRAFFIC_CROWD_HOLD_EN, same stimulus as the crowd case → timer keeps decrementing and hold_active stays 0. Assert reset_n mid-B_GO → outputs return to 90/95, A GREEN.

Source files
------------

// File: rtl/traffic_phase_controller_pkg.sv
// Shared types and constants for the two-road intersection phase controller.
package traffic_pkg;

  localparam int unsigned TIMER_W         = 7;
  localparam int unsigned DEF_A_GO_TIME   = 90;
  localparam int unsigned DEF_B_GO_TIME   = 30;
  localparam int unsigned DEF_CLEAR_TIME  = 5;
  localparam int unsigned DEF_CROWD_TICKS = 10;

  localparam logic [TIMER_W-1:0] BLANK = 7'h7F;

  typedef enum logic [2:0] {
    A_GO    = 3'd0,
    A_CLEAR = 3'd1,
    B_GO    = 3'd2,
    B_CLEAR = 3'd3,
    POL_A   = 3'd4,
    POL_B   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    RED   = 2'b00,
    AMBER = 2'b01,
    GREEN = 2'b10
  } light_e;

  // Per-road display payload handed to the output registers.
  typedef struct packed {
    light_e               light;
    logic [TIMER_W-1:0]   remaining;
  } road_disp_t;

  function automatic state_e next_phase(input state_e s);
    state_e n;
    n = A_GO;
    case (s)
      A_GO:    n = A_CLEAR;
      A_CLEAR: n = B_GO;
      B_GO:    n = B_CLEAR;
      default: n = A_GO;
    endcase
    return n;
  endfunction

  function automatic logic is_police(input state_e s);
    return (s == POL_A) || (s == POL_B);
  endfunction

endpackage

// File: rtl/traffic_phase_controller_crowd_monitor.sv
// Saturating count of consecutive crowded ticks; clears on crowd loss or phase change.
module crowd_monitor #(
  parameter int unsigned CROWD_TICKS = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic crowd,
  input  logic clear,
  output logic saturated
);

  localparam int unsigned CNT_W = $clog2(CROWD_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CROWD_TICKS);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear || !crowd) begin
      cnt <= '0;
    end else if (tick && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign saturated = (cnt == CNT_MAX);

endmodule

// File: rtl/traffic_phase_controller.sv
// Phase sequencer with police override and optional crowd hold.
// Crowd hold is built only when TRAFFIC_CROWD_HOLD_EN is defined.
module traffic_phase_controller
  import traffic_pkg::*;
#(
  parameter int unsigned A_GO_TIME   = DEF_A_GO_TIME,
  parameter int unsigned B_GO_TIME   = DEF_B_GO_TIME,
  parameter int unsigned CLEAR_TIME  = DEF_CLEAR_TIME,
  parameter int unsigned CROWD_TICKS = DEF_CROWD_TICKS
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               tick,
  input  logic               crowd_a,
  input  logic               crowd_b,
  input  logic               police_a,
  input  logic               police_b,
  input  logic               police_clr,
  output logic [1:0]         light_a,
  output logic [1:0]         light_b,
  output logic [TIMER_W-1:0] time_a,
  output logic [TIMER_W-1:0] time_b,
  output logic               hold_active
);

  localparam logic [TIMER_W-1:0] A_DUR = TIMER_W'(A_GO_TIME);
  localparam logic [TIMER_W-1:0] B_DUR = TIMER_W'(B_GO_TIME);
  localparam logic [TIMER_W-1:0] C_DUR = TIMER_W'(CLEAR_TIME);

  state_e             state, nxt_state;
  logic [TIMER_W-1:0] timer, nxt_timer;
  logic               hold_c;
  road_disp_t         disp_a_c, disp_b_c;

  function automatic logic [TIMER_W-1:0] dur_of(input state_e s);
    logic [TIMER_W-1:0] d;
    d = C_DUR;
    case (s)
      A_GO:    d = A_DUR;
      B_GO:    d = B_DUR;
      default: d = C_DUR;
    endcase
    return d;
  endfunction

`ifdef TRAFFIC_CROWD_HOLD_EN
  logic crowd_sel_c, sat_c, state_chg_c;

  assign crowd_sel_c = ((state == A_GO) && crowd_a) || ((state == B_GO) && crowd_b);
  assign state_chg_c = (nxt_state != state);

  crowd_monitor #(
    .CROWD_TICKS (CROWD_TICKS)
  ) u_crowd_monitor (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick      (tick),
    .crowd     (crowd_sel_c),
    .clear     (state_chg_c),
    .saturated (sat_c)
  );

  assign hold_c = sat_c && crowd_sel_c;
`else
  localparam int unsigned unused_crowd_ticks = CROWD_TICKS;
  logic unused_crowd_c;

  assign unused_crowd_c = ^{crowd_a, crowd_b};
  assign hold_c         = 1'b0;
`endif

  // Police requests dominate clear and tick; the timer only moves on tick outside police.
  always_comb begin
    nxt_state = state;
    nxt_timer = timer;
    if (police_a) begin
      nxt_state = POL_A;
    end else if (police_b) begin
      nxt_state = POL_B;
    end else if (police_clr && (state == POL_A)) begin
      nxt_state = A_CLEAR;
      nxt_timer = C_DUR;
    end else if (police_clr && (state == POL_B)) begin
      nxt_state = B_CLEAR;
      nxt_timer = C_DUR;
    end else if (tick && !is_police(state) && !hold_c) begin
      if (timer == TIMER_W'(1)) begin
        nxt_state = next_phase(state);
        nxt_timer = dur_of(next_phase(state));
      end else begin
        nxt_timer = timer - TIMER_W'(1);
      end
    end
  end

  // Display decode from the next state so outputs move on the same edge as the state.
  always_comb begin
    disp_a_c.light     = RED;
    disp_a_c.remaining = BLANK;
    disp_b_c.light     = RED;
    disp_b_c.remaining = BLANK;
    case (nxt_state)
      A_GO: begin
        disp_a_c.light     = GREEN;
        disp_a_c.remaining = nxt_timer;
        disp_b_c.remaining = nxt_timer + C_DUR;
      end
      A_CLEAR: begin
        disp_a_c.light     = AMBER;
        disp_a_c.remaining = nxt_timer;
        disp_b_c.remaining = nxt_timer;
      end
      B_GO: begin
        disp_b_c.light     = GREEN;
        disp_b_c.remaining = nxt_timer;
        disp_a_c.remaining = nxt_timer + C_DUR;
      end
      B_CLEAR: begin
        disp_b_c.light     = AMBER;
        disp_a_c.remaining = nxt_timer;
        disp_b_c.remaining = nxt_timer;
      end
      POL_A:   disp_a_c.light = GREEN;
      POL_B:   disp_b_c.light = GREEN;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= A_GO;
      timer       <= A_DUR;
      light_a     <= GREEN;
      light_b     <= RED;
      time_a      <= A_DUR;
      time_b      <= A_DUR + C_DUR;
      hold_active <= 1'b0;
    end else begin
      state       <= nxt_state;
      timer       <= nxt_timer;
      light_a     <= disp_a_c.light;
      light_b     <= disp_b_c.light;
      time_a      <= disp_a_c.remaining;
      time_b      <= disp_b_c.remaining;
      hold_active <= hold_c && (nxt_state == state);
    end
  end

endmodule
